// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one Avalon-MM memory port between the instruction-fetch requester
// and the data (load/store) requester. One transaction at a time; the data
// side wins a tie. Address, command, byte enables and write data are held
// while waitrequest is high. Read data comes back right-justified and
// zero-extended, together with a one-cycle ack to the requester that won.
// Misaligned data accesses are acked at once with d_misalign and do not
// touch the bus.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   When defined, a transfer is abandoned after TIMEOUT_CYCLES cycles of
//   waitrequest. The owner is then acked with rdata=0 and bus_err=1.
//   When undefined there is no bus_err port and the bus waits indefinitely.
module mem_bus_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              d_misalign,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    output logic [DATA_W-1:0] writedata,
    output logic [3:0]        byteenable,
    input  logic [DATA_W-1:0] readdata,
    input  logic              waitrequest,
`ifdef MEM_TIMEOUT_EN
    output logic              bus_err,
`endif
    output logic              busy
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Size 11 is reserved and always rejected.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] k);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = k[0];
            SZ_WORD: bad = (k != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] k);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << k;
            SZ_HALF: be = k[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the right-justified store data across every lane it may land in.
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] res;
        case (size)
            SZ_BYTE: res = {4{wd[7:0]}};
            SZ_HALF: res = {2{wd[15:0]}};
            default: res = wd;
        endcase
        return res;
    endfunction

    // Pull the addressed lane down to bit 0 and zero-extend it.
    function automatic logic [31:0] lane_rdata(input logic [1:0] size, input logic [1:0] k,
                                               input logic [31:0] rd);
        logic [31:0] sh;
        logic [31:0] res;
        sh = rd >> {k, 3'b000};
        case (size)
            SZ_BYTE: res = {24'h000000, sh[7:0]};
            SZ_HALF: res = {16'h0000, sh[15:0]};
            default: res = rd;
        endcase
        return res;
    endfunction

    state_t            state_r, state_s;
    logic              owner_r, owner_s;          // 1 = data side, 0 = fetch
    logic [1:0]        size_r, size_s;
    logic [1:0]        lane_r, lane_s;
    logic              we_r, we_s;
    logic [ADDR_W-1:0] address_r, address_s;
    logic              read_r, read_s;
    logic              write_r, write_s;
    logic [DATA_W-1:0] writedata_r, writedata_s;
    logic [3:0]        be_r, be_s;
    logic [DATA_W-1:0] if_rdata_r, if_rdata_s;
    logic              if_ack_r, if_ack_s;
    logic [DATA_W-1:0] d_rdata_r, d_rdata_s;
    logic              d_ack_r, d_ack_s;
    logic              mis_r, mis_s;
    logic              busy_r, busy_s;

    // Fetch is always a word access, so its low address bits carry no meaning.
    logic unused_s;
    assign unused_s = ^if_addr[1:0];

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             berr_r, berr_s;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

    // Next-state and next-output logic; every output register is fed from here.
    always_comb begin
        state_s     = state_r;
        owner_s     = owner_r;
        size_s      = size_r;
        lane_s      = lane_r;
        we_s        = we_r;
        address_s   = address_r;
        read_s      = read_r;
        write_s     = write_r;
        writedata_s = writedata_r;
        be_s        = be_r;
        if_rdata_s  = if_rdata_r;
        d_rdata_s   = d_rdata_r;
        if_ack_s    = 1'b0;
        d_ack_s     = 1'b0;
        mis_s       = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_s       = cnt_r;
        berr_s      = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (d_req) begin
                    owner_s = 1'b1;
                    size_s  = d_size;
                    lane_s  = d_addr[1:0];
                    we_s    = d_we;
                    if (is_misaligned(d_size, d_addr[1:0])) begin
                        state_s   = ST_RESP;
                        d_ack_s   = 1'b1;
                        mis_s     = 1'b1;
                        d_rdata_s = {DATA_W{1'b0}};
                    end else begin
                        state_s     = ST_BUS;
                        address_s   = {d_addr[ADDR_W-1:2], 2'b00};
                        be_s        = lane_be(d_size, d_addr[1:0]);
                        writedata_s = lane_wdata(d_size, d_wdata);
                        read_s      = ~d_we;
                        write_s     = d_we;
`ifdef MEM_TIMEOUT_EN
                        cnt_s       = {CNT_W{1'b0}};
`endif
                    end
                end else if (if_req) begin
                    owner_s   = 1'b0;
                    size_s    = SZ_WORD;
                    lane_s    = 2'b00;
                    we_s      = 1'b0;
                    state_s   = ST_BUS;
                    address_s = {if_addr[ADDR_W-1:2], 2'b00};
                    be_s      = 4'b1111;
                    read_s    = 1'b1;
                    write_s   = 1'b0;
`ifdef MEM_TIMEOUT_EN
                    cnt_s     = {CNT_W{1'b0}};
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (!waitrequest) begin
                    read_s  = 1'b0;
                    write_s = 1'b0;
                    state_s = ST_RESP;
                    if (owner_r) begin
                        d_ack_s   = 1'b1;
                        d_rdata_s = we_r ? {DATA_W{1'b0}} : lane_rdata(size_r, lane_r, readdata);
                    end else begin
                        if_ack_s   = 1'b1;
                        if_rdata_s = readdata;
                    end
                end else begin
`ifdef MEM_TIMEOUT_EN
                    if (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        read_s  = 1'b0;
                        write_s = 1'b0;
                        state_s = ST_RESP;
                        berr_s  = 1'b1;
                        if (owner_r) begin
                            d_ack_s   = 1'b1;
                            d_rdata_s = {DATA_W{1'b0}};
                        end else begin
                            if_ack_s   = 1'b1;
                            if_rdata_s = {DATA_W{1'b0}};
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
`else
                    state_s = ST_BUS;
`endif
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                read_s  = 1'b0;
                write_s = 1'b0;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers; reset abandons any transfer in flight without an ack.
    always_ff @(posedge clk) begin
        if (Rst) begin
            state_r     <= ST_IDLE;
            owner_r     <= 1'b0;
            size_r      <= 2'b00;
            lane_r      <= 2'b00;
            we_r        <= 1'b0;
            address_r   <= {ADDR_W{1'b0}};
            read_r      <= 1'b0;
            write_r     <= 1'b0;
            writedata_r <= {DATA_W{1'b0}};
            be_r        <= 4'b0000;
            if_rdata_r  <= {DATA_W{1'b0}};
            if_ack_r    <= 1'b0;
            d_rdata_r   <= {DATA_W{1'b0}};
            d_ack_r     <= 1'b0;
            mis_r       <= 1'b0;
            busy_r      <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_r       <= {CNT_W{1'b0}};
            berr_r      <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            owner_r     <= owner_s;
            size_r      <= size_s;
            lane_r      <= lane_s;
            we_r        <= we_s;
            address_r   <= address_s;
            read_r      <= read_s;
            write_r     <= write_s;
            writedata_r <= writedata_s;
            be_r        <= be_s;
            if_rdata_r  <= if_rdata_s;
            if_ack_r    <= if_ack_s;
            d_rdata_r   <= d_rdata_s;
            d_ack_r     <= d_ack_s;
            mis_r       <= mis_s;
            busy_r      <= busy_s;
`ifdef MEM_TIMEOUT_EN
            cnt_r       <= cnt_s;
            berr_r      <= berr_s;
`endif
        end
    end

    assign address    = address_r;
    assign read       = read_r;
    assign write      = write_r;
    assign writedata  = writedata_r;
    assign byteenable = be_r;
    assign if_rdata   = if_rdata_r;
    assign if_ack     = if_ack_r;
    assign d_rdata    = d_rdata_r;
    assign d_ack      = d_ack_r;
    assign d_misalign = mis_r;
    assign busy       = busy_r;
`ifdef MEM_TIMEOUT_EN
    assign bus_err    = berr_r;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: the stimulus pushes the expected ack
// response and the expected Avalon command; two monitors check them as the DUT
// presents them. A small slave process drives waitrequest.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        Rst;
    logic        if_req, d_req, d_we, waitrequest;
    logic [31:0] if_addr, d_addr, d_wdata, readdata;
    logic [1:0]  d_size;
    logic [31:0] if_rdata, d_rdata, address, writedata;
    logic        if_ack, d_ack, d_misalign, read, write, busy;
    logic [3:0]  byteenable;
`ifdef MEM_TIMEOUT_EN
    logic        bus_err;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int wait_left = 0;

    typedef struct {
        logic        is_data;
        logic [31:0] rdata;
        logic        chk_rd;
        logic        mis;
        logic        berr;
    } resp_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        int          len;
    } cmd_t;

    resp_t respq[$];
    cmd_t  cmdq[$];
    cmd_t  cur;
    bit    in_cmd = 1'b0;
    int    ncyc = 0;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .Rst(Rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_misalign(d_misalign),
        .address(address), .read(read), .write(write), .writedata(writedata),
        .byteenable(byteenable), .readdata(readdata), .waitrequest(waitrequest),
`ifdef MEM_TIMEOUT_EN
        .bus_err(bus_err),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Ack monitor: pops one expected response per ack.
    always @(negedge clk) begin
        if (if_ack || d_ack) begin
            if (respq.size() == 0) begin
                chk("unexpected_ack", {30'd0, if_ack, d_ack}, 32'd0);
            end else begin
                resp_t e;
                e = respq.pop_front();
                chk("ack_owner", {30'd0, if_ack, d_ack}, {30'd0, ~e.is_data, e.is_data});
                chk("misalign", {31'd0, d_misalign}, {31'd0, e.mis});
                if (e.chk_rd) chk("rdata", e.is_data ? d_rdata : if_rdata, e.rdata);
`ifdef MEM_TIMEOUT_EN
                chk("bus_err", {31'd0, bus_err}, {31'd0, e.berr});
`endif
            end
        end
    end

    // Command monitor: each cycle read/write is high must match the expected command.
    always @(negedge clk) begin
        if (read || write) begin
            if (!in_cmd) begin
                if (cmdq.size() == 0) begin
                    chk("unexpected_cmd", {30'd0, read, write}, 32'd0);
                    cur = '{1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 0};
                end else begin
                    cur = cmdq.pop_front();
                end
                in_cmd = 1'b1;
                ncyc = 0;
            end
            chk("cmd_rw", {30'd0, read, write}, {30'd0, cur.rd, cur.wr});
            chk("address", address, cur.addr);
            chk("byteenable", {28'd0, byteenable}, {28'd0, cur.be});
            if (cur.wr) chk("writedata", writedata, cur.wd);
            ncyc++;
        end else if (in_cmd) begin
            chk("cmd_cycles", ncyc, cur.len);
            in_cmd = 1'b0;
        end
    end

    // Avalon slave: holds waitrequest for wait_left cycles of each command.
    initial begin
        waitrequest = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if ((read || write) && wait_left > 0) begin
                waitrequest = 1'b1;
                wait_left--;
            end else begin
                waitrequest = 1'b0;
            end
        end
    end

    task automatic wait_ack(input bit data, input int exp_lat);
        bit got = 1'b0;
        int n = 0;
        for (int i = 1; i <= 300 && !got; i++) begin
            @(posedge clk);
            #1;
            if (data ? d_ack : if_ack) begin
                got = 1'b1;
                n = i;
            end
        end
        if (!got) begin
            chk(data ? "d_ack_timeout" : "if_ack_timeout", 32'd0, 32'd1);
        end else begin
            chk("latency", n, exp_lat);
            chk("busy_in_ack", {31'd0, busy}, 32'd1);
        end
        if (data) d_req = 1'b0;
        else if_req = 1'b0;
        @(posedge clk);
        #1;
        if (got) chk("busy_after", {31'd0, busy}, 32'd0);
    endtask

    task automatic run_data(input logic we, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] bus_rd, input int waits,
                            input logic mis, input logic [3:0] be_e, input logic [31:0] wd_e,
                            input logic [31:0] rd_e);
        respq.push_back('{1'b1, rd_e, (!we || mis), mis, 1'b0});
        if (!mis) cmdq.push_back('{!we, we, {addr[31:2], 2'b00}, be_e, wd_e, waits + 1});
        readdata = bus_rd;
        wait_left = waits;
        d_we = we; d_size = size; d_addr = addr; d_wdata = wd;
        d_req = 1'b1;
        wait_ack(1'b1, mis ? 1 : waits + 2);
    endtask

    task automatic run_fetch(input logic [31:0] addr, input logic [31:0] bus_rd, input int waits);
        respq.push_back('{1'b0, bus_rd, 1'b1, 1'b0, 1'b0});
        cmdq.push_back('{1'b1, 1'b0, {addr[31:2], 2'b00}, 4'b1111, 32'd0, waits + 1});
        readdata = bus_rd;
        wait_left = waits;
        if_addr = addr;
        if_req = 1'b1;
        wait_ack(1'b0, waits + 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst = 1'b1;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_size = 2'b00;
        if_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0; readdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rw", {30'd0, read, write}, 32'd0);
        chk("rst_acks", {29'd0, if_ack, d_ack, d_misalign}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_address", address, 32'd0);
        chk("rst_be", {28'd0, byteenable}, 32'd0);
        chk("rst_rdata", if_rdata | d_rdata | writedata, 32'd0);
        Rst = 1'b0;
        @(posedge clk);
        #1;

        // T1: fetch, no wait, minimum latency
        run_fetch(32'hBFC00000, 32'h24020005, 0);
        // Fetch with low address bits set is forced to a word access
        run_fetch(32'h00400006, 32'hCAFEF00D, 1);

        // T2: simultaneous requests, data store wins, fetch served next
        respq.push_back('{1'b1, 32'd0, 1'b0, 1'b0, 1'b0});
        respq.push_back('{1'b0, 32'h8C220000, 1'b1, 1'b0, 1'b0});
        cmdq.push_back('{1'b0, 1'b1, 32'h00001000, 4'b1000, 32'hABABABAB, 1});
        cmdq.push_back('{1'b1, 1'b0, 32'h00000104, 4'b1111, 32'd0, 1});
        readdata = 32'h8C220000;
        wait_left = 0;
        d_we = 1'b1; d_size = 2'b00; d_addr = 32'h00001003; d_wdata = 32'h000000AB;
        if_addr = 32'h00000104;
        d_req = 1'b1;
        if_req = 1'b1;
        wait_ack(1'b1, 2);
        wait_ack(1'b0, 2);

        // T3: load word held through 5 waitrequest cycles
        run_data(1'b0, 2'b10, 32'h00002000, 32'd0, 32'hDEADBEEF, 5, 1'b0, 4'b1111, 32'd0, 32'hDEADBEEF);
        // T4 and other misaligned cases: no bus cycle, immediate ack
        run_data(1'b0, 2'b10, 32'h00002002, 32'd0, 32'h55555555, 0, 1'b1, 4'b0000, 32'd0, 32'd0);
        run_data(1'b0, 2'b01, 32'h00002001, 32'd0, 32'h55555555, 0, 1'b1, 4'b0000, 32'd0, 32'd0);
        run_data(1'b1, 2'b11, 32'h00002000, 32'h1234, 32'd0, 0, 1'b1, 4'b0000, 32'd0, 32'd0);
        // T5: byte loads, half loads/stores, word store with waits
        run_data(1'b0, 2'b00, 32'h00002001, 32'd0, 32'h11F23344, 0, 1'b0, 4'b0010, 32'd0, 32'h00000033);
        run_data(1'b0, 2'b00, 32'h00002003, 32'd0, 32'h11F23344, 1, 1'b0, 4'b1000, 32'd0, 32'h00000011);
        run_data(1'b0, 2'b01, 32'h00002002, 32'd0, 32'h11F23344, 0, 1'b0, 4'b1100, 32'd0, 32'h000011F2);
        run_data(1'b0, 2'b01, 32'h00002000, 32'd0, 32'h11F2B344, 0, 1'b0, 4'b0011, 32'd0, 32'h0000B344);
        run_data(1'b1, 2'b01, 32'h00003000, 32'h0000BEEF, 32'd0, 0, 1'b0, 4'b0011, 32'hBEEFBEEF, 32'd0);
        run_data(1'b1, 2'b00, 32'h00003000, 32'h00000077, 32'd0, 0, 1'b0, 4'b0001, 32'h77777777, 32'd0);
        run_data(1'b1, 2'b10, 32'h00003004, 32'h12345678, 32'd0, 2, 1'b0, 4'b1111, 32'h12345678, 32'd0);

        // T5 reset: reset lands during BUS; read drops, no ack ever appears
        cmdq.push_back('{1'b1, 1'b0, 32'h00002000, 4'b0010, 32'd0, 2});
        readdata = 32'h11F23344;
        wait_left = 10;
        d_we = 1'b0; d_size = 2'b00; d_addr = 32'h00002001;
        d_req = 1'b1;
        @(posedge clk);
        #1;
        chk("pre_rst_read", {31'd0, read}, 32'd1);
        @(posedge clk);
        #1;
        Rst = 1'b1;
        d_req = 1'b0;
        @(posedge clk);
        #1;
        wait_left = 0;
        chk("post_rst_read", {31'd0, read}, 32'd0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        Rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

`ifdef MEM_TIMEOUT_EN
        // T6: waitrequest stuck high, transfer abandoned after 4 cycles
        respq.push_back('{1'b1, 32'd0, 1'b1, 1'b0, 1'b1});
        cmdq.push_back('{1'b1, 1'b0, 32'h00004000, 4'b1111, 32'd0, 4});
        readdata = 32'h99999999;
        wait_left = 1000;
        d_we = 1'b0; d_size = 2'b10; d_addr = 32'h00004000;
        d_req = 1'b1;
        wait_ack(1'b1, 5);
        wait_left = 0;
`endif

        // One final load after everything else still works
        run_data(1'b0, 2'b10, 32'h00005000, 32'd0, 32'h0BADC0DE, 0, 1'b0, 4'b1111, 32'd0, 32'h0BADC0DE);

        repeat (3) @(posedge clk);
        #1;
        chk("resp_queue_empty", respq.size(), 32'd0);
        chk("cmd_queue_empty", cmdq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
